graphics_bus_writer: RTL and testbench
======================================

# graphics_bus_writer

Bus master that pushes the game state (paddle positions, ball position/depth, scores, game state) into the graphics ASIC's register file over the chipselect/databus/data_address write interface, one 16-bit register per cycle. It sits on the CPU/game-logic side and is the writer for the graphics ASIC's receiver. Transfers are launched only at frame boundaries so the display never shows a half-updated frame. After the first full transfer, only changed registers are rewritten.

## Interface
Parameters:
- GFX_CS, 4'b0001, chipselect code asserted during writes; 4'b0000 when idle.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- update  in  1  one-cycle request: game state inputs are new
- frame_sync  in  1  one-cycle pulse at end of frame (VGA_ready with last pixel address 19'h4AFFF)
- paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y  in  16 each  paddle positions
- ball_x, ball_y, ball_z  in  16 each  ball position; ball_z 0..999
- player_1_score, player_2_score  in  16 each  scores
- game_state  in  16  game state word
- chipselect  out  4  GFX_CS during a write cycle, else 0
- databus  out  16  write data; 0 when idle
- data_address  out  4  register index; 0 when idle
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when a transfer completes

## Operation
- Register map (data_address): 0 paddle_1_x, 1 paddle_1_y, 2 paddle_2_x, 3 paddle_2_y, 4 ball_x, 5 ball_y, 6 ball_z, 7 player_1_score, 8 player_2_score, 9 game_state. Addresses 10–15 are never driven.
- pending flag: set by update; cleared when a transfer starts. Updates are merged, not queued: several updates before a frame_sync produce one transfer.
- States: IDLE, SEND, FINISH.
- IDLE: on an edge where frame_sync=1 and (pending=1 or update=1), snapshot all 10 inputs into snap registers, clear pending, set idx=0, go to SEND, and set busy=1. frame_sync without a request does nothing.
- SEND: each edge processes idx. If force_all=1 or snap[idx]≠shadow[idx], the outputs register chipselect=GFX_CS, data_address=idx, databus=snap[idx]. Otherwise the outputs register the idle values. shadow[idx]<=snap[idx], then idx increments. After idx=9, go to FINISH.
- FINISH: outputs go idle, busy<=0, done<=1 for one cycle, force_all<=0, and the block returns to IDLE.
- An update during SEND or FINISH sets pending. frame_sync during SEND or FINISH is ignored; the transfer waits for the next frame_sync.
- Inputs change freely during a transfer; only the snapshot is written.
- Reset values: chipselect=0, databus=0, data_address=0, busy=0, done=0, pending=0, force_all=1, shadow=0, state IDLE.
- Reset mid-transfer: the transfer is abandoned and outputs are idle on the next cycle. Because force_all=1, the next transfer rewrites all 10 registers.

## Timing
- All outputs are registered.
- Start edge E0: busy=1 from E0.
- Edges E1..E10 register writes for idx 0..9; each write is visible for exactly one cycle.
- Edge E11: outputs idle, busy=0, done=1.
- Edge E12: done=0.
- Transfer length is always 11 cycles of busy, regardless of how many registers changed. Skipped registers leave a one-cycle idle gap at their slot position.
- Earliest next start is E12, given frame_sync and a request.
- update and frame_sync in the same cycle while IDLE start the transfer at that edge.

## Test plan
- Reset: hold rst 2 cycles -> all outputs 0, busy=0. frame_sync alone -> no write, busy stays 0.
- First transfer: inputs 100,200,350,250,320,240,0,1,2,3; update, then frame_sync 5 cycles later -> 10 writes with cs=GFX_CS on addresses 0..9 in consecutive cycles, databus matching; done pulses at E11.
- Delta transfer: change only ball_z to 10, then update plus frame_sync -> exactly one write (addr 6, data 10) in the cycle after E7; busy still lasts 11 cycles.
- Request merging: three updates (ball_z 20, 30, 40) with no frame_sync, then one frame_sync -> one transfer writing addr 6 = 40.
- Busy overlap: update at E3 of a transfer with ball_x changed to 321; frame_sync at E5 is ignored; the next frame_sync after E11 starts a transfer writing addr 4 = 321.
- Reset mid-transfer: assert rst at E4 -> outputs idle the next cycle. The next update plus frame_sync writes all 10 addresses even though the values are unchanged.

Source files
------------

// File: rtl/graphics_bus_writer.sv
// Pushes a snapshot of the game state into the graphics ASIC's register file at frame boundaries.
// After the first full transfer, only registers whose value changed are rewritten.
module graphics_bus_writer #(
  parameter logic [3:0] GFX_CS = 4'b0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic        frame_sync,
  input  logic [15:0] paddle_1_x,
  input  logic [15:0] paddle_1_y,
  input  logic [15:0] paddle_2_x,
  input  logic [15:0] paddle_2_y,
  input  logic [15:0] ball_x,
  input  logic [15:0] ball_y,
  input  logic [15:0] ball_z,
  input  logic [15:0] player_1_score,
  input  logic [15:0] player_2_score,
  input  logic [15:0] game_state,
  output logic [3:0]  chipselect,
  output logic [15:0] databus,
  output logic [3:0]  data_address,
  output logic        busy,
  output logic        done
);
  localparam int NREG = 10;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_FINISH} state_t;

  state_t      r_state, w_next;
  logic [15:0] w_in     [0:NREG-1];
  logic [15:0] r_snap   [0:NREG-1];
  logic [15:0] r_shadow [0:NREG-1];
  logic [3:0]  r_idx;
  logic        r_pending, r_force_all;
  logic        w_start, w_wr, w_last;

  assign w_in[0] = paddle_1_x;
  assign w_in[1] = paddle_1_y;
  assign w_in[2] = paddle_2_x;
  assign w_in[3] = paddle_2_y;
  assign w_in[4] = ball_x;
  assign w_in[5] = ball_y;
  assign w_in[6] = ball_z;
  assign w_in[7] = player_1_score;
  assign w_in[8] = player_2_score;
  assign w_in[9] = game_state;

  assign w_start = (r_state == S_IDLE) && frame_sync && (r_pending || update);
  assign w_wr    = r_force_all || (r_snap[r_idx] != r_shadow[r_idx]);
  assign w_last  = (r_idx == 4'(NREG - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_SEND;
      S_SEND:   if (w_last)  w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_pending    <= 1'b0;
      r_force_all  <= 1'b1;
      chipselect   <= '0;
      databus      <= '0;
      data_address <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        r_snap[i]   <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      r_state      <= w_next;
      chipselect   <= '0;
      databus      <= '0;
      data_address <= '0;
      done         <= 1'b0;
      // Requests merge: a start consumes every update seen so far, including one on the start edge.
      if (w_start)     r_pending <= 1'b0;
      else if (update) r_pending <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            for (int i = 0; i < NREG; i++) r_snap[i] <= w_in[i];
            r_idx <= '0;
            busy  <= 1'b1;
          end
        end
        S_SEND: begin
          if (w_wr) begin
            chipselect   <= GFX_CS;
            data_address <= r_idx;
            databus      <= r_snap[r_idx];
          end
          r_shadow[r_idx] <= r_snap[r_idx];
          r_idx           <= r_idx + 4'd1;
        end
        S_FINISH: begin
          busy        <= 1'b0;
          done        <= 1'b1;
          r_force_all <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_graphics_bus_writer.sv
// Directed bench for graphics_bus_writer: full, delta, merged, overlapped and reset-aborted transfers.
module tb_graphics_bus_writer;
  logic        clk = 0;
  logic        rst, update, frame_sync;
  logic [15:0] p1x, p1y, p2x, p2y, bx, by, bz, s1, s2, gs;
  logic [3:0]  chipselect, data_address;
  logic [15:0] databus;
  logic        busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  graphics_bus_writer #(.GFX_CS(4'b0001)) dut (
    .clk(clk), .rst(rst), .update(update), .frame_sync(frame_sync),
    .paddle_1_x(p1x), .paddle_1_y(p1y), .paddle_2_x(p2x), .paddle_2_y(p2y),
    .ball_x(bx), .ball_y(by), .ball_z(bz),
    .player_1_score(s1), .player_2_score(s2), .game_state(gs),
    .chipselect(chipselect), .databus(databus), .data_address(data_address),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cs"},   32'(chipselect),   32'h0);
    chk({tag, "_addr"}, 32'(data_address), 32'h0);
    chk({tag, "_data"}, 32'(databus),      32'h0);
  endtask

  // Caller has set frame_sync (and optionally update) for edge E0.
  // mask selects which slots must carry a write; upd_e/fs_e inject pulses at that edge (-1 = none).
  task automatic run_xfer(input string tag, input logic [9:0] mask,
                          input int upd_e, input int fs_e, input logic [15:0] bx_new);
    logic [15:0] exp [10];
    exp[0] = p1x; exp[1] = p1y; exp[2] = p2x; exp[3] = p2y; exp[4] = bx;
    exp[5] = by;  exp[6] = bz;  exp[7] = s1;  exp[8] = s2;  exp[9] = gs;
    tick();
    update = 0; frame_sync = 0;
    chk({tag, "_E0_busy"}, 32'(busy), 32'h1);
    chk_idle({tag, "_E0"});
    for (int e = 1; e <= 10; e++) begin
      update     = (e == upd_e);
      frame_sync = (e == fs_e);
      if (e == upd_e) bx = bx_new;
      tick();
      update = 0; frame_sync = 0;
      chk($sformatf("%s_E%0d_busy", tag, e), 32'(busy), 32'h1);
      chk($sformatf("%s_E%0d_done", tag, e), 32'(done), 32'h0);
      if (mask[e-1]) begin
        chk($sformatf("%s_E%0d_cs", tag, e),   32'(chipselect),   32'h1);
        chk($sformatf("%s_E%0d_addr", tag, e), 32'(data_address), 32'(e-1));
        chk($sformatf("%s_E%0d_data", tag, e), 32'(databus),      32'(exp[e-1]));
      end else begin
        chk_idle($sformatf("%s_E%0d", tag, e));
      end
    end
    tick();
    chk({tag, "_E11_busy"}, 32'(busy), 32'h0);
    chk({tag, "_E11_done"}, 32'(done), 32'h1);
    chk_idle({tag, "_E11"});
    tick();
    chk({tag, "_E12_done"}, 32'(done), 32'h0);
    chk({tag, "_E12_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    rst = 1; update = 0; frame_sync = 0;
    p1x = 0; p1y = 0; p2x = 0; p2y = 0; bx = 0; by = 0; bz = 0; s1 = 0; s2 = 0; gs = 0;
    tick(); tick();
    chk_idle("rst");
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 0;

    // frame_sync alone does nothing
    frame_sync = 1; tick(); frame_sync = 0;
    tick();
    chk("fs_only_busy", 32'(busy), 32'h0);
    chk_idle("fs_only");

    // first transfer: everything written
    p1x = 100; p1y = 200; p2x = 350; p2y = 250; bx = 320; by = 240; bz = 0; s1 = 1; s2 = 2; gs = 3;
    update = 1; tick(); update = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_first_busy", 32'(busy), 32'h0);
    frame_sync = 1;
    run_xfer("first", 10'h3FF, -1, -1, 16'h0);

    // delta: only ball_z, update and frame_sync together
    bz = 10; update = 1; frame_sync = 1;
    run_xfer("delta", 10'h040, -1, -1, 16'h0);

    // merging: three updates, one transfer with the last value
    bz = 20; update = 1; tick();
    bz = 30; tick();
    bz = 40; tick(); update = 0;
    tick();
    chk("merge_wait_busy", 32'(busy), 32'h0);
    frame_sync = 1;
    run_xfer("merge", 10'h040, -1, -1, 16'h0);

    // overlap: update at E3 with ball_x changed, frame_sync at E5 ignored
    bz = 41; update = 1; frame_sync = 1;
    run_xfer("ovl", 10'h040, 3, 5, 16'd321);
    tick();
    chk("ovl_after_busy", 32'(busy), 32'h0);
    frame_sync = 1;
    run_xfer("ovl2", 10'h010, -1, -1, 16'h0);

    // reset mid-transfer
    update = 1; frame_sync = 1; tick(); update = 0; frame_sync = 0;
    tick(); tick(); tick();
    chk("mid_E3_busy", 32'(busy), 32'h1);
    rst = 1; tick(); rst = 0;
    chk_idle("mid_rst");
    chk("mid_rst_busy", 32'(busy), 32'h0);
    tick();
    update = 1; frame_sync = 1;
    run_xfer("post_rst", 10'h3FF, -1, -1, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
